// File: rtl/byte_packer_if.sv
// byte_packer_if: groups the byte-stream input handshake and the packed-word
// output handshake of byte_packer.
//   in_valid/in_data/in_last/in_ready : byte stream from producer
//   out_valid/out_data/out_count/out_ready : packed frame to consumer
// Modports:
//   slave  - the packer (receives bytes, emits frames)
//   master - the environment (drives bytes, consumes frames)
interface byte_packer_if #(
    parameter int NBYTES = 32,
    parameter int CW     = 6
);
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_last;
    logic                  in_ready;
    logic                  out_valid;
    logic [8*NBYTES-1:0]   out_data;
    logic [CW-1:0]         out_count;
    logic                  out_ready;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count
    );
endinterface

// File: rtl/byte_packer.sv
// byte_packer: collects 8-bit bytes under a valid/ready handshake and packs
// them into one 8*NBYTES-bit word, first byte in the lowest lane. A frame
// closes after NBYTES bytes or on a byte flagged in_last, and is then held
// stable until the consumer takes it.
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous, active-high reset; discards any partial frame
//   bus   - byte_packer_if.slave (byte input and packed-word output)
module byte_packer #(
    parameter int NBYTES = 32,
    parameter int CW     = 6
) (
    input  logic          clk,
    input  logic          reset,
    byte_packer_if.slave  bus
);
    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [8*NBYTES-1:0]   data_q, data_d;
    logic [CW-1:0]         count_q, count_d;

    // Handshake outputs come straight from the state register, so there is
    // no combinational path from in_valid or out_ready.
    assign bus.in_ready  = (state_q == FILL);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_data  = data_q;
    assign bus.out_count = count_q;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        count_d = count_q;
        case (state_q)
            FILL: begin
                if (bus.in_valid) begin
                    // Lanes not yet written are still zero from the last
                    // clear, so a short frame reads 0 in its unused lanes.
                    for (int k = 0; k < NBYTES; k++) begin
                        if (count_q == CW'(k)) begin
                            data_d[8*k +: 8] = bus.in_data;
                        end
                    end
                    count_d = count_q + CW'(1);
                    // Closing at NBYTES keeps the counter from ever wrapping.
                    if (bus.in_last || (count_q == CW'(NBYTES - 1))) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d = FILL;
                    data_d  = '0;
                    count_d = '0;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FILL;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_byte_packer.sv
// tb_byte_packer: directed testbench for byte_packer. Inputs change and
// outputs are sampled on the falling clock edge; the DUT acts on the rising.
module tb_byte_packer;
    localparam int NBYTES = 32;
    localparam int CW     = 6;

    logic clk;
    logic reset;
    int   npass;
    int   ntotal;

    byte_packer_if #(.NBYTES(NBYTES), .CW(CW)) bus ();

    byte_packer #(.NBYTES(NBYTES), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [255:0] FULL_A =
        256'h1F1E1D1C1B1A191817161514131211100F0E0D0C0B0A09080706050403020100;
    localparam logic [255:0] FULL_B =
        256'h9F9E9D9C9B9A999897969594939291908F8E8D8C8B8A89888786858483828180;

    task automatic test_reset();
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.in_last = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        ntotal++;
        if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", bus.out_valid);
        else npass++;
        ntotal++;
        if (bus.out_count !== 6'd0) $display("FAIL reset_out_count got %0d want 0", bus.out_count);
        else npass++;
        ntotal++;
        if (bus.out_data !== 256'h0) $display("FAIL reset_out_data got %h want 0", bus.out_data);
        else npass++;
        ntotal++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
        else npass++;
    endtask

    task automatic test_short_frame();
        bus.in_valid = 1'b1; bus.in_data = 8'h06; bus.in_last = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
        ntotal++;
        if (bus.out_valid !== 1'b1) $display("FAIL short_out_valid got %b want 1", bus.out_valid);
        else npass++;
        ntotal++;
        if (bus.out_count !== 6'd1) $display("FAIL short_out_count got %0d want 1", bus.out_count);
        else npass++;
        ntotal++;
        if (bus.out_data !== 256'h6) $display("FAIL short_out_data got %h want 6", bus.out_data);
        else npass++;
        ntotal++;
        if (bus.in_ready !== 1'b0) $display("FAIL short_in_ready got %b want 0", bus.in_ready);
        else npass++;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        ntotal++;
        if (bus.in_ready !== 1'b1 || bus.out_count !== 6'd0 || bus.out_data !== 256'h0)
            $display("FAIL short_release got rdy=%b cnt=%0d data=%h want rdy=1 cnt=0 data=0",
                     bus.in_ready, bus.out_count, bus.out_data);
        else npass++;
        // in_last without in_valid must not close anything.
        bus.in_last = 1'b1;
        @(negedge clk);
        bus.in_last = 1'b0;
        ntotal++;
        if (bus.out_valid !== 1'b0 || bus.out_count !== 6'd0)
            $display("FAIL last_no_accept got vld=%b cnt=%0d want vld=0 cnt=0",
                     bus.out_valid, bus.out_count);
        else npass++;
    endtask

    task automatic test_full_frame();
        for (int i = 0; i < NBYTES; i++) begin
            if (i == NBYTES - 1) begin
                ntotal++;
                if (bus.out_valid !== 1'b0 || bus.out_count !== 6'd31 || bus.in_ready !== 1'b1)
                    $display("FAIL full_pre_close got vld=%b cnt=%0d rdy=%b want vld=0 cnt=31 rdy=1",
                             bus.out_valid, bus.out_count, bus.in_ready);
                else npass++;
            end
            bus.in_valid = 1'b1; bus.in_data = 8'(i); bus.in_last = 1'b0;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        ntotal++;
        if (bus.out_valid !== 1'b1) $display("FAIL full_out_valid got %b want 1", bus.out_valid);
        else npass++;
        ntotal++;
        if (bus.out_count !== 6'd32) $display("FAIL full_out_count got %0d want 32", bus.out_count);
        else npass++;
        ntotal++;
        if (bus.out_data !== FULL_A) $display("FAIL full_out_data got %h want %h", bus.out_data, FULL_A);
        else npass++;
        ntotal++;
        if (bus.in_ready !== 1'b0) $display("FAIL full_in_ready got %b want 0", bus.in_ready);
        else npass++;
    endtask

    // Runs on the frame left in HOLD by test_full_frame.
    task automatic test_backpressure();
        bus.in_valid = 1'b1; bus.in_data = 8'hAA; bus.out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            ntotal++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 ||
                bus.out_count !== 6'd32 || bus.out_data !== FULL_A)
                $display("FAIL bp_hold_%0d got rdy=%b vld=%b cnt=%0d data=%h want rdy=0 vld=1 cnt=32 data=%h",
                         c, bus.in_ready, bus.out_valid, bus.out_count, bus.out_data, FULL_A);
            else npass++;
        end
        // in_valid stays high across the release edge: nothing may be taken.
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0; bus.in_valid = 1'b0;
        ntotal++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
            $display("FAIL bp_release got rdy=%b vld=%b want rdy=1 vld=0", bus.in_ready, bus.out_valid);
        else npass++;
        ntotal++;
        if (bus.out_count !== 6'd0 || bus.out_data !== 256'h0)
            $display("FAIL bp_release_clear got cnt=%0d data=%h want cnt=0 data=0",
                     bus.out_count, bus.out_data);
        else npass++;
    endtask

    task automatic test_reset_mid_fill();
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1; bus.in_data = 8'(8'h10 + i); bus.in_last = 1'b0;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        ntotal++;
        if (bus.out_count !== 6'd10) $display("FAIL midfill_count got %0d want 10", bus.out_count);
        else npass++;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        ntotal++;
        if (bus.out_count !== 6'd0 || bus.out_data !== 256'h0 || bus.in_ready !== 1'b1)
            $display("FAIL midfill_reset got cnt=%0d data=%h rdy=%b want cnt=0 data=0 rdy=1",
                     bus.out_count, bus.out_data, bus.in_ready);
        else npass++;
        bus.in_valid = 1'b1; bus.in_data = 8'h55; bus.in_last = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
        ntotal++;
        if (bus.out_valid !== 1'b1 || bus.out_count !== 6'd1 || bus.out_data !== 256'h55)
            $display("FAIL midfill_frame got vld=%b cnt=%0d data=%h want vld=1 cnt=1 data=55",
                     bus.out_valid, bus.out_count, bus.out_data);
        else npass++;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int sent;
        int frames;
        int rise0;
        int rise1;
        sent = 0; frames = 0; rise0 = 0; rise1 = 0;
        bus.out_ready = 1'b1; bus.in_last = 1'b0;
        for (int cyc = 0; cyc < 200 && frames < 2; cyc++) begin
            if (bus.out_valid === 1'b1) begin
                if (frames == 0) begin
                    rise0 = cyc;
                    ntotal++;
                    if (bus.out_count !== 6'd32 || bus.out_data !== FULL_A)
                        $display("FAIL b2b_frame0 got cnt=%0d data=%h want cnt=32 data=%h",
                                 bus.out_count, bus.out_data, FULL_A);
                    else npass++;
                end else begin
                    rise1 = cyc;
                    ntotal++;
                    if (bus.out_count !== 6'd32 || bus.out_data !== FULL_B)
                        $display("FAIL b2b_frame1 got cnt=%0d data=%h want cnt=32 data=%h",
                                 bus.out_count, bus.out_data, FULL_B);
                    else npass++;
                end
                frames++;
            end
            // in_ready is registered, so it predicts the accept at the next edge.
            if (bus.in_ready === 1'b1 && sent < 2*NBYTES) begin
                bus.in_valid = 1'b1;
                bus.in_data  = (sent < NBYTES) ? 8'(sent) : 8'(8'h80 + sent - NBYTES);
                sent++;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        ntotal++;
        if (frames != 2) $display("FAIL b2b_frames got %0d want 2 (timeout)", frames);
        else npass++;
        ntotal++;
        if (rise1 - rise0 != 33) $display("FAIL b2b_spacing got %0d want 33", rise1 - rise0);
        else npass++;
    endtask

    initial begin
        npass = 0;
        ntotal = 0;
        test_reset();
        test_short_frame();
        test_full_frame();
        test_backpressure();
        test_reset_mid_fill();
        test_back_to_back();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule

// File: doc/byte_packer.md
# byte_packer

Upstream stage of the splitter datapath: collects a stream of 8-bit bytes under a valid/ready handshake and packs them into one 256-bit word. That word drives the splitter's 256-bit input. A frame closes when 32 bytes have arrived or a byte is flagged last. The frame is held stable until the consumer accepts it.

## Interface
- NBYTES, 32, bytes per packed word; the output width is 8*NBYTES.
- CW, 6, width of the byte counter; must hold NBYTES.
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  producer offers in_data this cycle.
- in_data  input  8  byte offered.
- in_last  input  1  qualifies in_data; this byte closes the frame early.
- in_ready  output  1  block accepts a byte this cycle.
- out_valid  output  1  out_data/out_count hold a complete frame.
- out_data  output  8*NBYTES  packed word; byte k at bits [8k+7:8k], first byte at k=0.
- out_count  output  CW  number of valid bytes in the frame, 1..NBYTES.
- out_ready  input  1  consumer takes the frame this cycle.

## Operation
- Two states: FILL and HOLD.
- Reset (synchronous, at the clk edge with reset=1):
  - state=FILL, out_data=0, out_count=0, out_valid=0.
  - in_ready is therefore 1 from the first cycle after reset.
  - Reset wins over every other event in the same cycle.
- FILL:
  - in_ready=1, out_valid=0.
  - Accept is the condition in_valid && in_ready.
  - On accept, in_data is written to byte lane out_count and out_count increments.
  - If the accepted byte makes out_count==NBYTES, or in_last=1, go to HOLD.
- HOLD:
  - in_ready=0, out_valid=1.
  - out_data and out_count are frozen regardless of in_valid.
  - On out_valid && out_ready: go to FILL, clear out_data to 0, clear out_count to 0.
- Unused lanes of a short frame read 0.
- in_last with no accept is ignored.
- out_count never wraps: the frame always closes at NBYTES.
- Reset in the middle of a frame discards all partial bytes; no frame is emitted.
- in_ready and out_valid are decoded directly from the state register: no combinational path from in_valid or out_ready.

## Timing
- Byte accept latency: the byte is visible in out_data the cycle after the accepting edge.
- Frame close: out_valid rises the cycle after the accept of byte NBYTES or of the last-flagged byte.
- Release: in_ready rises the cycle after the out_valid&&out_ready edge.
- The block never accepts input and releases a frame on the same edge.
- Steady-state throughput with out_ready=1: one 32-byte frame per 33 cycles.
- out_valid stays high until the output handshake completes; there is no timeout.

## Test plan
- Reset check: after reset, out_valid=0, out_count=0, out_data=0 and in_ready=1.
- Single short frame:
  - Stimulus: one byte 0x06 with in_last=1, matching the splitter's 256'b110 case.
  - Required: next cycle out_valid=1, out_count=1, out_data=256'h6.
- Full frame:
  - Stimulus: stream bytes 0x00..0x1F back-to-back with in_valid=1.
  - Required: out_valid rises after the 32nd accept; out_count=32; out_data=256'h1F1E...0100.
  - in_ready=0 while out_valid=1.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles with in_valid=1 and in_data=0xAA.
  - Required: no accepts, and out_data/out_count unchanged.
  - After out_ready pulses, in_ready=1 the next cycle and out_count=0.
- Reset mid-fill:
  - Stimulus: accept 10 bytes, assert reset for 1 cycle, then send one byte 0x55 with in_last=1.
  - Required: frame has out_count=1 and out_data=256'h55; no stale bytes.
- Back-to-back frames:
  - Stimulus: two 32-byte frames with out_ready tied to 1.
  - Required: second frame's out_valid rises exactly 33 cycles after the first's; both frames are correct.
